// File: rtl/led_pkg.sv
// LED breathing controller shared types.
// Mode and ramp-state encodings plus the reset phase helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_SAW     = 2'b11
  } mode_e;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } ramp_st_e;

  // Staggered start level so channels are spread across the ramp
  function automatic int ch_phase(
    input int i,
    input int ch,
    input int dw
  );
    return (i << dw) / ch;
  endfunction

endpackage

// File: rtl/led_ramp_ch.sv
// Per-channel brightness ramp: BREATHE triangle or SAW sawtooth.
// Level and direction advance only on prescaler ticks.
module led_ramp_ch
  import led_pkg::*;
#(
  parameter int CH  = 4,
  parameter int DW  = 8,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic [1:0]    mode,
  output logic [DW-1:0] level,
  output logic          cyc_done
);

  localparam logic [DW-1:0] MAXV = '1;
  localparam logic [DW-1:0] RST_LVL =
    DW'(ch_phase(IDX, CH, DW));

  ramp_st_e      st;
  ramp_st_e      st_nx;
  logic [DW-1:0] lvl_nx;
  logic          done_nx;

  logic up_go;
  logic up_top;
  logic dn_go;
  logic dn_bot;

  assign up_go  = (st == ST_UP) && (level != MAXV);
  assign up_top = (st == ST_UP) && (level == MAXV);
  assign dn_go  = (st == ST_DOWN) && (level != '0);
  assign dn_bot = (st == ST_DOWN) && (level == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_UP;
      level    <= RST_LVL;
      cyc_done <= 1'b0;
    end else begin
      st       <= st_nx;
      level    <= lvl_nx;
      cyc_done <= done_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    lvl_nx  = level;
    done_nx = 1'b0;
    if (en && tick) begin
      unique case (mode_e'(mode))
        MODE_BREATHE: begin
          unique case (1'b1)
            up_go: begin
              lvl_nx = level + DW'(1);
            end
            up_top: begin
              st_nx  = ST_DOWN;
              lvl_nx = MAXV - DW'(1);
            end
            dn_go: begin
              lvl_nx = level - DW'(1);
            end
            dn_bot: begin
              st_nx   = ST_UP;
              lvl_nx  = DW'(1);
              done_nx = 1'b1;
            end
            default: ;
          endcase
        end
        MODE_SAW: begin
          // Sawtooth always climbs; leave UP so BREATHE resumes upward
          st_nx = ST_UP;
          if (level == MAXV) begin
            lvl_nx  = '0;
            done_nx = 1'b1;
          end else begin
            lvl_nx = level + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/led_breath_pwm.sv
// Multi-channel LED breathing controller with shared-counter PWM.
// Prescaler and PWM counter are shared; each channel owns a ramp.
module led_breath_pwm
  import led_pkg::*;
#(
  parameter int CH = 4,
  parameter int DW = 8,
  parameter int PW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PW-1:0]   step_div,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   pwm_out,
  output logic [CH*DW-1:0] level,
  output logic [CH-1:0]   cyc_done
);

  localparam logic [DW-1:0] MAXV    = '1;
  localparam logic [DW-1:0] CNT_TOP = MAXV - DW'(1);

  logic [PW-1:0] pre;
  logic [DW-1:0] pwm_cnt;
  logic          tick;
  logic [CH-1:0] pwm_nx;
  logic [DW-1:0] lvl [CH];

  // Plain equality: a count above a shrunk step_div wraps around
  assign tick = en && (pre == step_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= '0;
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_nx;
      if (en) begin
        pre     <= tick ? '0 : pre + PW'(1);
        pwm_cnt <= (pwm_cnt == CNT_TOP) ? '0
                 : pwm_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < CH; i++) begin
      unique case (mode_e'(mode[2*i +: 2]))
        MODE_OFF: pwm_nx[i] = 1'b0;
        MODE_ON:  pwm_nx[i] = 1'b1;
        default:  pwm_nx[i] = lvl[i] > pwm_cnt;
      endcase
    end
    if (!en) pwm_nx = '0;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    led_ramp_ch #(
      .CH (CH),
      .DW (DW),
      .IDX(g)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .tick    (tick),
      .mode    (mode[2*g +: 2]),
      .level   (lvl[g]),
      .cyc_done(cyc_done[g])
    );
    assign level[DW*g +: DW] = lvl[g];
  end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Scoreboard bench for led_breath_pwm.
// Phase-based reference model predicts every post-edge output.
module tb_led_breath_pwm;

  localparam int CH  = 4;
  localparam int DW  = 8;
  localparam int PW  = 16;
  localparam int MAX = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [PW-1:0]   step_div;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   pwm_out;
  logic [CH*DW-1:0] level;
  logic [CH-1:0]   cyc_done;

  always #5 clk = ~clk;

  led_breath_pwm #(.CH(CH), .DW(DW), .PW(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .step_div(step_div),
    .mode    (mode),
    .pwm_out (pwm_out),
    .level   (level),
    .cyc_done(cyc_done)
  );

  typedef struct packed {
    logic [CH*DW-1:0] lv;
    logic [CH-1:0]    pw;
    logic [CH-1:0]    cd;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Ramp position: 0..MAX rising, MAX+1..2*MAX falling (2*MAX = low end)
  int ph[CH];
  int m_pre;
  int m_cnt;

  function automatic int mlvl(input int i);
    return (ph[i] <= MAX) ? ph[i] : 2 * MAX - ph[i];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < CH; i++) ph[i] = (i * (MAX + 1)) / CH;
    m_pre = 0;
    m_cnt = 0;
  endtask

  // Predict the next edge from current inputs, then advance one cycle
  task automatic step();
    exp_t e;
    bit tk;
    logic [1:0] md;
    e = '0;
    if (rst) begin
      mreset();
    end else begin
      tk = en && (m_pre == int'(step_div));
      for (int i = 0; i < CH; i++) begin
        md = mode[2*i +: 2];
        e.pw[i] = en && (md == 2'b01 || (md[1] && mlvl(i) > m_cnt));
      end
      if (en) begin
        m_cnt = (m_cnt + 1) % MAX;
        m_pre = tk ? 0 : (m_pre + 1) % (1 << PW);
      end
      if (tk) begin
        for (int i = 0; i < CH; i++) begin
          md = mode[2*i +: 2];
          if (md == 2'b10) begin
            if (ph[i] == 2 * MAX) begin
              ph[i] = 1;
              e.cd[i] = 1'b1;
            end else begin
              ph[i]++;
            end
          end else if (md == 2'b11) begin
            if (mlvl(i) == MAX) begin
              ph[i] = 0;
              e.cd[i] = 1'b1;
            end else begin
              ph[i] = mlvl(i) + 1;
            end
          end
        end
      end
    end
    for (int i = 0; i < CH; i++) e.lv[DW*i +: DW] = DW'(mlvl(i));
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_div(input int v);
    int n;
    n = 0;
    while (m_pre > v && n < 2000) begin
      step();
      n++;
    end
    chk("set_div_bound", 64'(m_pre > v), 64'(0));
    step_div = PW'(v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("level", 64'(level), 64'(e.lv));
        chk("pwm_out", 64'(pwm_out), 64'(e.pw));
        chk("cyc_done", 64'(cyc_done), 64'(e.cd));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hi[CH];
    int pulses, mx, mn, chg, n, v, c;
    logic [DW-1:0] prev;
    rst = 1'b1;
    en = 1'b0;
    step_div = PW'(1000);
    mode = 8'b10_10_10_10;
    #1;
    chk("rst_level", 64'(level), 64'(32'hC0_80_40_00));
    chk("rst_pwm", 64'(pwm_out), 64'(0));
    chk("rst_done", 64'(cyc_done), 64'(0));
    @(negedge clk);
    step();
    rst = 1'b0;
    en = 1'b1;

    // Levels held by slow prescaler: duty equals level per period
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int k = 0; k < MAX; k++) begin
      step();
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
    end
    chk("duty_l0", 64'(hi[0]), 64'(0));
    chk("duty_l64", 64'(hi[1]), 64'(64));
    chk("duty_l128", 64'(hi[2]), 64'(128));
    chk("duty_l192", 64'(hi[3]), 64'(192));

    // Full breathe period at one step per cycle
    set_div(0);
    pulses = 0;
    mx = 0;
    mn = MAX;
    for (int k = 0; k < 2 * MAX; k++) begin
      step();
      pulses += int'(cyc_done[0]);
      if (int'(level[7:0]) > mx) mx = int'(level[7:0]);
      if (int'(level[7:0]) < mn) mn = int'(level[7:0]);
    end
    chk("breathe_pulses", 64'(pulses), 64'(1));
    chk("breathe_max", 64'(mx), 64'(MAX));
    chk("breathe_min", 64'(mn), 64'(0));

    // Step every 4 enabled cycles
    set_div(3);
    prev = level[7:0];
    chg = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (level[7:0] != prev) chg++;
      prev = level[7:0];
    end
    chk("div3_changes", 64'(chg), 64'(100));

    // Sawtooth on ch1, hand over to breathe mid-ramp
    set_div(0);
    mode[3:2] = 2'b11;
    n = 0;
    while (mlvl(1) != 100 && n < 600) begin
      step();
      n++;
    end
    chk("saw_at100", 64'(level[15:8]), 64'(100));
    mode[3:2] = 2'b10;
    step();
    chk("saw_to_breathe", 64'(level[15:8]), 64'(101));
    mode[3:2] = 2'b11;
    n = 0;
    while (mlvl(1) != MAX && n < 600) begin
      step();
      n++;
    end
    step();
    chk("saw_wrap_level", 64'(level[15:8]), 64'(0));
    chk("saw_wrap_done", 64'(cyc_done[1]), 64'(1));

    // Forced pins, then a disabled stretch
    mode = 8'b10_10_01_00;
    for (int k = 0; k < 20; k++) step();
    chk("off_on_pins", 64'(pwm_out[1:0]), 64'(2'b10));
    mode = 8'b11_10_10_10;
    set_div(2);
    en = 1'b0;
    for (int k = 0; k < 50; k++) step();
    chk("dis_pwm", 64'(pwm_out), 64'(0));
    en = 1'b1;
    for (int k = 0; k < 20; k++) step();

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) begin
        c = int'($urandom_range(0, CH - 1));
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1))
          : int'($urandom_range(2, 3));
        mode[2*c +: 2] = 2'(v);
      end
      if ($urandom_range(0, 99) == 0) begin
        v = int'($urandom_range(0, 3));
        if (m_pre <= v) step_div = PW'(v);
      end
      step();
    end

    // Reset while running
    rst = 1'b1;
    #1;
    chk("mid_rst_level", 64'(level), 64'(32'hC0_80_40_00));
    chk("mid_rst_pwm", 64'(pwm_out), 64'(0));
    chk("mid_rst_done", 64'(cyc_done), 64'(0));
    step();
    rst = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 30; k++) step();

    @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
